bias_pingpong_buffer: RTL and testbench

- Parametrised, double-buffered bias store for the convolution output stage.
- Accepts bias words from the AXI-side stream at AXI_WIDTH bits per beat and packs R = CH_OUT*BIAS_W/AXI_WIDTH beats into one wide entry, so each entry holds one bias per output channel.
- Loads the inactive bank while the compute engine reads the active bank, so bias reload for the next layer hides behind the current layer.
- Bank swap is explicit. A swap requested during a load is deferred until the load ends.

---
 rtl/bias_pingpong_buffer.sv | 181 ++++++++++++++++++
 tb/tb_bias_pingpong_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_pingpong_buffer.sv
// Double-buffered bias store. AXI beats are packed into wide entries and
// written to the inactive bank. The compute side reads the active bank.
// Bank swaps requested during a load are held until that load finishes.
module bias_pingpong_buffer #(
    parameter int AXI_WIDTH = 64,
    parameter int CH_OUT    = 8,
    parameter int BIAS_W    = 32,
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [ADDR_W:0]            load_len,
    input  logic [AXI_WIDTH-1:0]       s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       loading,
    output logic                       load_done,
    input  logic                       swap,
    output logic                       active_bank,
    output logic                       active_loaded,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [CH_OUT*BIAS_W-1:0]   rd_data,
    output logic                       rd_valid
);

    localparam int ENTRY_W = CH_OUT * BIAS_W;
    localparam int R       = ENTRY_W / AXI_WIDTH;
    localparam int BEAT_W  = (R > 1) ? $clog2(R) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(R - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    // Reject geometries the packing and addressing logic cannot represent.
    generate
        if (R < 1 || (R & (R - 1)) != 0 || R * AXI_WIDTH != ENTRY_W ||
            DEPTH != (1 << ADDR_W)) begin : g_param_check
            $error("bias_pingpong_buffer: invalid parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     len;
    logic [ADDR_W:0]     entry;
    logic [BEAT_W-1:0]   beat;
    logic [ENTRY_W-1:0]  pack;
    logic [ENTRY_W-1:0]  pack_next;
    logic [1:0]          loaded;
    logic                swap_pending;
    logic                inactive_bank;
    logic                start_target;
    logic [ADDR_W:0]     len_sat;
    logic                accept;
    logic                wr_en;
    logic [ADDR_W:0]     wr_addr;

    logic [ENTRY_W-1:0]  mem [2*DEPTH];

    assign inactive_bank = ~active_bank;
    assign active_loaded = loaded[active_bank];
    assign accept        = s_valid & s_ready;
    assign wr_en         = (state == LOAD) && accept && (beat == BEAT_LAST);
    assign wr_addr       = {inactive_bank, entry[ADDR_W-1:0]};
    assign len_sat       = (load_len > LEN_MAX) ? LEN_MAX : load_len;
    // A swap in the same cycle as load_start retargets the load to the bank
    // that becomes inactive after the swap (the currently active one).
    assign start_target  = swap ? active_bank : inactive_bank;

    // Merge the current beat into its lane of the pack register.
    always_comb begin
        pack_next = pack;
        for (int unsigned i = 0; i < R; i++) begin
            if (beat == BEAT_W'(i)) begin
                pack_next[i*AXI_WIDTH +: AXI_WIDTH] = s_data;
            end
        end
    end

    // Load/swap controller with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len          <= '0;
            entry        <= '0;
            beat         <= '0;
            pack         <= '0;
            loaded       <= '0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            s_ready      <= 1'b0;
            loading      <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (swap) begin
                        active_bank <= ~active_bank;
                    end
                    if (load_start) begin
                        len                  <= len_sat;
                        loaded[start_target] <= 1'b0;
                        entry                <= '0;
                        beat                 <= '0;
                        if (len_sat == '0) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                            loading <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (swap) begin
                        swap_pending <= 1'b1;
                    end
                    if (accept) begin
                        if (beat == BEAT_LAST) begin
                            beat <= '0;
                            if (entry == len - LEN_ONE) begin
                                state     <= DONE;
                                s_ready   <= 1'b0;
                                loading   <= 1'b0;
                                load_done <= 1'b1;
                            end else begin
                                entry <= entry + LEN_ONE;
                            end
                        end else begin
                            beat <= beat + BEAT_ONE;
                            pack <= pack_next;
                        end
                    end
                end
                DONE: begin
                    loaded[inactive_bank] <= 1'b1;
                    if (swap || swap_pending) begin
                        active_bank <= ~active_bank;
                    end
                    swap_pending <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bank storage write port; the full entry is written on its last beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pack_next;
        end
    end

    // Registered single-cycle read from the bank active at request time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[{active_bank, rd_addr}];
            end
        end
    end

endmodule

// File: tb/tb_bias_pingpong_buffer.sv
// Directed bench for bias_pingpong_buffer with default parameters (R = 4).
module tb_bias_pingpong_buffer;

    logic         clk;
    logic         rst_n;
    logic         load_start;
    logic [7:0]   load_len;
    logic [63:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         loading;
    logic         load_done;
    logic         swap;
    logic         active_bank;
    logic         active_loaded;
    logic         rd_en;
    logic [6:0]   rd_addr;
    logic [255:0] rd_data;
    logic         rd_valid;

    int checks = 0;
    int errors = 0;

    bias_pingpong_buffer #(
        .AXI_WIDTH (64),
        .CH_OUT    (8),
        .BIAS_W    (32),
        .DEPTH     (128),
        .ADDR_W    (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_len      (load_len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .loading       (loading),
        .load_done     (load_done),
        .swap          (swap),
        .active_bank   (active_bank),
        .active_loaded (active_loaded),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry built from four consecutive 64-bit beats starting at 'first'.
    function automatic logic [255:0] exp_entry(input logic [63:0] first);
        return {first + 64'd3, first + 64'd2, first + 64'd1, first};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus driver: issues load_start then streams beats base, base+1, ...
    // Leaves the bench in the cycle right after the final accepted beat.
    task automatic drive_load(input int len, input logic [63:0] base,
                              input bit toggle, input bit swap_at_start,
                              output int ready_cnt, output bit ok);
        int eff;
        int beats;
        int idx;
        int cyc;
        bit acc;
        eff = (len > 128) ? 128 : len;
        beats = eff * 4;
        idx = 0;
        cyc = 0;
        ready_cnt = 0;
        load_start = 1'b1;
        load_len = 8'(len);
        swap = swap_at_start;
        tick;
        load_start = 1'b0;
        swap = 1'b0;
        while (idx < beats && cyc < 5000) begin
            s_valid = toggle ? (cyc[0] == 1'b0) : 1'b1;
            s_data = base + 64'(idx);
            acc = s_valid && s_ready;
            if (s_ready) ready_cnt++;
            tick;
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        ok = (idx == beats);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load_start = 1'b0; load_len = '0; s_data = '0; s_valid = 1'b0;
        swap = 1'b0; rd_en = 1'b0; rd_addr = '0;
        #12;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading: got %b expected 0", loading); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL reset_active_bank: got %b expected 0", active_bank); end
        checks++; if (active_loaded !== 1'b0) begin errors++; $display("FAIL reset_active_loaded: got %b expected 0", active_loaded); end
        checks++; if (rd_data !== 256'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic_load;
        int rc;
        bit ok;
        drive_load(2, 64'd0, 1'b0, 1'b0, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: got %b expected 1", ok); end
        checks++; if (rc !== 8) begin errors++; $display("FAIL basic_ready_cycles: got %0d expected 8", rc); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done: got %b expected 1", load_done); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_after: got %b expected 0", s_ready); end
        tick;
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", load_done); end
        checks++; if (active_loaded !== 1'b0) begin errors++; $display("FAIL basic_loaded_preswap: got %b expected 0", active_loaded); end
        swap = 1'b1;
        tick;
        swap = 1'b0;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL basic_swap_bank: got %b expected 1", active_bank); end
        checks++; if (active_loaded !== 1'b1) begin errors++; $display("FAIL basic_loaded_postswap: got %b expected 1", active_loaded); end
        rd_en = 1'b1; rd_addr = 7'd0;
        tick;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== exp_entry(64'd0)) begin errors++; $display("FAIL basic_rd_entry0: got %h expected %h", rd_data, exp_entry(64'd0)); end
        rd_addr = 7'd1;
        tick;
        checks++; if (rd_data !== exp_entry(64'd4)) begin errors++; $display("FAIL basic_rd_entry1: got %h expected %h", rd_data, exp_entry(64'd4)); end
        rd_en = 1'b0; rd_addr = 7'd0;
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_valid_idle: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== exp_entry(64'd4)) begin errors++; $display("FAIL basic_rd_hold: got %h expected %h", rd_data, exp_entry(64'd4)); end
    endtask

    task automatic test_toggle_valid;
        int rc;
        bit ok;
        drive_load(2, 64'd0, 1'b1, 1'b0, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL toggle_timeout: got %b expected 1", ok); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL toggle_load_done: got %b expected 1", load_done); end
        tick;
        swap = 1'b1;
        tick;
        swap = 1'b0;
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL toggle_bank: got %b expected 0", active_bank); end
        rd_en = 1'b1; rd_addr = 7'd0;
        tick;
        checks++; if (rd_data !== exp_entry(64'd0)) begin errors++; $display("FAIL toggle_entry0: got %h expected %h", rd_data, exp_entry(64'd0)); end
        rd_addr = 7'd1;
        tick;
        checks++; if (rd_data !== exp_entry(64'd4)) begin errors++; $display("FAIL toggle_entry1: got %h expected %h", rd_data, exp_entry(64'd4)); end
        rd_en = 1'b0;
        tick;
    endtask

    task automatic test_concurrent_read;
        // Bank 0 is active with pattern A (base 0); bank 1 receives pattern B.
        rd_en = 1'b1; rd_addr = 7'd0;
        load_start = 1'b1; load_len = 8'd2;
        tick;
        load_start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 64'h100 + 64'(i);
            swap = (i == 3) || (i == 5);
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_entry(64'd0)) begin errors++; $display("FAIL conc_read_A[%0d]: got %b/%h expected 1/%h", i, rd_valid, rd_data, exp_entry(64'd0)); end
            checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL conc_bank_hold[%0d]: got %b expected 0", i, active_bank); end
            tick;
        end
        swap = 1'b0;
        s_valid = 1'b0;
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL conc_load_done: got %b expected 1", load_done); end
        checks++; if (active_bank !== 1'b0) begin errors++; $display("FAIL conc_bank_in_done: got %b expected 0", active_bank); end
        tick;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL conc_bank_after_done: got %b expected 1", active_bank); end
        checks++; if (active_loaded !== 1'b1) begin errors++; $display("FAIL conc_loaded: got %b expected 1", active_loaded); end
        checks++; if (rd_data !== exp_entry(64'd0)) begin errors++; $display("FAIL conc_read_done_cycle: got %h expected %h", rd_data, exp_entry(64'd0)); end
        rd_addr = 7'd1;
        tick;
        checks++; if (rd_data !== exp_entry(64'h104)) begin errors++; $display("FAIL conc_read_B: got %h expected %h", rd_data, exp_entry(64'h104)); end
        rd_en = 1'b0;
        tick;
        tick;
        checks++; if (active_bank !== 1'b1) begin errors++; $display("FAIL conc_single_toggle: got %b expected 1", active_bank); end
    endtask

    task automatic test_len_limits;
        int rc;
        bit ok;
        // Zero length: completes immediately without opening the stream.
        load_start = 1'b1; load_len = 8'd0;
        tick;
        load_start = 1'b0;
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_load_done: got %b expected 1", load_done); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL zero_s_ready: got %b expected 0", s_ready); end
        tick;
        checks++; if (load_done !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b ready=%b expected 0/0", load_done, s_ready); end
        // Oversized length saturates at DEPTH entries.
        drive_load(200, 64'h1000, 1'b0, 1'b0, rc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL big_timeout: got %b expected 1", ok); end
        checks++; if (rc !== 512) begin errors++; $display("FAIL big_ready_cycles: got %0d expected 512", rc); end
        checks++; if (load_done !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL big_done: got done=%b ready=%b expected 1/0", load_done, s_ready); end
        tick;
        swap = 1'b1;
        tick;
        swap = 1'b0;
        checks++; if (active_bank !== 1'b0 || active_loaded !== 1'b1) begin errors++; $display("FAIL big_swap: got bank=%b loaded=%b expected 0/1", active_bank, active_loaded); end
        rd_en = 1'b1; rd_addr = 7'd127;
        tick;
        checks++; if (rd_data !== exp_entry(64'h1000 + 64'd508)) begin errors++; $display("FAIL big_entry127: got %h expected %h", rd_data, exp_entry(64'h1000 + 64'd508)); end
        rd_addr = 7'd0;
        tick;
        checks++; if (rd_data !== exp_entry(64'h1000)) begin errors++; $display("FAIL big_entry0: got %h expected %h", rd_data, exp_entry(64'h1000)); end
        rd_en = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_load;
        int rc;
        bit ok;
        load_start = 1'b1; load_len = 8'd2;
        tick;
        load_start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 64'h500 + 64'(i);
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0 || loading !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got ready=%b loading=%b done=%b expected 0/0/0", s_ready, loading, load_done); end
        checks++; if (active_bank !== 1'b0 || active_loaded !== 1'b0) begin errors++; $display("FAIL rst_mid_bank: got bank=%b loaded=%b expected 0/0", active_bank, active_loaded); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 256'd0) begin errors++; $display("FAIL rst_mid_read: got %b/%h expected 0/0", rd_valid, rd_data); end
        s_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        drive_load(1, 64'h2000, 1'b0, 1'b0, rc, ok);
        checks++; if (ok !== 1'b1 || load_done !== 1'b1) begin errors++; $display("FAIL rst_fresh_done: got ok=%b done=%b expected 1/1", ok, load_done); end
        tick;
        checks++; if (active_loaded !== 1'b0) begin errors++; $display("FAIL rst_bank0_flag: got %b expected 0", active_loaded); end
        swap = 1'b1;
        tick;
        swap = 1'b0;
        checks++; if (active_bank !== 1'b1 || active_loaded !== 1'b1) begin errors++; $display("FAIL rst_fresh_swap: got bank=%b loaded=%b expected 1/1", active_bank, active_loaded); end
        rd_en = 1'b1; rd_addr = 7'd0;
        tick;
        rd_en = 1'b0;
        checks++; if (rd_data !== exp_entry(64'h2000)) begin errors++; $display("FAIL rst_fresh_data: got %h expected %h", rd_data, exp_entry(64'h2000)); end
        tick;
    endtask

    task automatic test_swap_with_start;
        int rc;
        bit ok;
        // Active is bank 1 (loaded); bank 0 flag was cleared by reset.
        drive_load(1, 64'h3000, 1'b0, 1'b1, rc, ok);
        checks++; if (ok !== 1'b1 || load_done !== 1'b1) begin errors++; $display("FAIL sws_done: got ok=%b done=%b expected 1/1", ok, load_done); end
        checks++; if (active_bank !== 1'b0 || active_loaded !== 1'b0) begin errors++; $display("FAIL sws_bank: got bank=%b loaded=%b expected 0/0", active_bank, active_loaded); end
        tick;
        rd_en = 1'b1; rd_addr = 7'd0;
        tick;
        rd_en = 1'b0;
        checks++; if (rd_data !== exp_entry(64'h1000)) begin errors++; $display("FAIL sws_bank0_untouched: got %h expected %h", rd_data, exp_entry(64'h1000)); end
        swap = 1'b1;
        tick;
        swap = 1'b0;
        checks++; if (active_bank !== 1'b1 || active_loaded !== 1'b1) begin errors++; $display("FAIL sws_swap_back: got bank=%b loaded=%b expected 1/1", active_bank, active_loaded); end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        checks++; if (rd_data !== exp_entry(64'h3000)) begin errors++; $display("FAIL sws_bank1_data: got %h expected %h", rd_data, exp_entry(64'h3000)); end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic_load;
        test_toggle_valid;
        test_concurrent_read;
        test_len_limits;
        test_reset_mid_load;
        test_swap_with_start;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck design cannot hang the run.
    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
